stream_mux_arb: RTL and testbench

- Parametrised successor to the team's combinational 4:1 bit mux.
- N-channel, W-bit data mux with per-channel valid/ready handshake and a registered output stage.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Sits between multiple producer streams and a single consumer; sustains one transfer per cycle.

---
 rtl/mux_pkg.sv | 18 +
 rtl/stream_mux_arb_rr_arbiter.sv | 50 +++++
 rtl/stream_mux_arb.sv | 128 ++++++++++++
 tb/tb_stream_mux_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the stream_mux_arb codebase slice.
//
// Contents:
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   sel_width()          : width of a channel index for an n-channel mux.
//                          It never returns 0, so a select port always
//                          has at least one bit.

package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant over NCH requesters.
//
// Ports:
//   req     [NCH]  in   request vector (one bit per channel)
//   ptr     [SELW] in   last-served channel; the scan starts at ptr+1
//   gnt     [NCH]  out  one-hot grant, or all-zero when nothing requests
//   gnt_idx [SELW] out  index of the granted channel (0 when no grant)
//
// The scan visits ptr+1, ptr+2, ... and wraps from NCH-1 to 0 by explicit
// compare. NCH therefore need not be a power of two.

module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] idx;
    logic            found;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path
        // through the block leaves a value unassigned (no inferred latch).
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = ptr;
        // NOTE: combinational scan uses blocking '=' so each iteration sees
        // the idx updated by the previous one; clocked state uses '<='.
        for (int k = 0; k < NCH; k++) begin
            if (idx == SELW'(NCH - 1)) begin
                idx = '0;
            end else begin
                idx = idx + 1'b1;
            end
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with valid/ready handshakes, fixed or
// round-robin selection, and a single registered output slot.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   mode       in   MODE_FIXED: use sel; MODE_RR: round-robin arbitration
//   sel        in   channel index used in fixed mode
//   in_data    in   NCH*W packed channel data, channel c at [c*W +: W]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready, at most one bit high
//   out_data   out  registered output data
//   out_ch     out  channel that supplied out_data
//   out_valid  out  output slot holds a beat
//   out_ready  in   consumer accepts the beat
//
// The output slot may reload in the same cycle it is consumed, so a stream
// runs at one beat per clock with one cycle of latency.

module stream_mux_arb
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int W    = 8,
    localparam int SELW = sel_width(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    // Output slot and round-robin pointer.
    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_ch_q,    out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] rr_ptr_q,    rr_ptr_d;

    // Grant path.
    logic [NCH-1:0]  rr_gnt;
    logic [SELW-1:0] rr_idx;
    logic [NCH-1:0]  fix_gnt;
    logic [NCH-1:0]  gnt;
    logic [SELW-1:0] gnt_idx;
    logic            can_load;
    logic            xfer;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Fixed-mode grant: an out-of-range sel grants nothing. The range test
    // short-circuits before in_valid is indexed.
    always_comb begin
        fix_gnt = '0;
        if (int'(sel) < NCH) begin
            if (in_valid[sel]) begin
                fix_gnt[sel] = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
        end else begin
            gnt     = fix_gnt;
            gnt_idx = sel;
        end
    end

    // The slot can take a new beat when it is empty or being drained now.
    assign can_load = !out_valid_q || out_ready;
    assign in_ready = gnt & {NCH{can_load}};
    // A grant implies its channel is valid, so a transfer is grant + space.
    assign xfer     = |in_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = in_data[int'(gnt_idx)*W +: W];
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            // Fixed-mode transfers move the pointer too, so a later switch
            // to round-robin resumes after the last-served channel.
            rr_ptr_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data/channel holding register is reset as well as the
            // valid flag because its reset value is visible on out_data/out_ch.
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb (NCH=4, W=8).
// Each table row is one clock cycle. Its expected in_ready vector is worked
// out by hand. A grant pushes {channel, data} onto a scoreboard, and the
// output slot is compared against the head of the scoreboard every cycle.
// Channel c carries {tag, c}, where tag is unique per row, so a stale or
// duplicated beat shows up as a data mismatch.

module tb_stream_mux_arb;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [1:0]      sel;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]  in_valid;
    logic [NCH-1:0]  in_ready;
    logic [W-1:0]    out_data;
    logic [1:0]      out_ch;
    logic            out_valid;
    logic            out_ready;

    stream_mux_arb #(
        .NCH (NCH),
        .W   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst_before;
        bit         mode;
        logic [1:0] sel;
        logic [3:0] valid;
        bit         ordy;
        logic [3:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } beat_t;

    vec_t  tbl[$];
    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit r, input bit m, input int s, input logic [3:0] v,
                                input bit o, input logic [3:0] e);
        vec_t t;
        t.rst_before = r;
        t.mode       = m;
        t.sel        = 2'(s);
        t.valid      = v;
        t.ordy       = o;
        t.exp_rdy    = e;
        tbl.push_back(t);
    endfunction

    task automatic drive_data(input logic [5:0] tag);
        for (int c = 0; c < NCH; c++) begin
            in_data[c*W +: W] = {tag, 2'(c)};
        end
    endtask

    // One-cycle synchronous reset pulse, then check the reset state.
    task automatic pulse_reset(input string name);
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_ch"},    32'(out_ch),    32'd0);
        check({name, "_out_data"},  32'(out_data),  32'd0);
    endtask

    // Apply one table row for one cycle, with all checks before the edge.
    task automatic run_row(input int i, input vec_t t);
        beat_t b;
        string nm;
        nm = $sformatf("row%0d", i);
        if (t.rst_before) pulse_reset({nm, "_rst"});
        mode      = t.mode;
        sel       = t.sel;
        in_valid  = t.valid;
        out_ready = t.ordy;
        drive_data(6'(i + 8));
        #1;
        check({nm, "_in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
        if (sb.size() > 0) begin
            check({nm, "_out_valid"}, 32'(out_valid), 32'd1);
            check({nm, "_out_ch"},    32'(out_ch),    32'(sb[0].ch));
            check({nm, "_out_data"},  32'(out_data),  32'(sb[0].data));
            if (t.ordy) void'(sb.pop_front());
        end else begin
            check({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        end
        for (int c = 0; c < NCH; c++) begin
            if (t.exp_rdy[c]) begin
                b.ch   = 2'(c);
                b.data = {6'(i + 8), 2'(c)};
                sb.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;

        // Fixed mode, sel=2, streaming. The initial reset leaves ptr=3.
        add(0, 0, 2, 4'b1111, 1, 4'b0100);
        add(0, 0, 2, 4'b1111, 1, 4'b0100);
        add(0, 0, 2, 4'b1111, 1, 4'b0100);
        // Round-robin after reset, all valid: 0,1,2,3,0,1.
        add(1, 1, 0, 4'b1111, 1, 4'b0001);
        add(0, 1, 0, 4'b1111, 1, 4'b0010);
        add(0, 1, 0, 4'b1111, 1, 4'b0100);
        add(0, 1, 0, 4'b1111, 1, 4'b1000);
        add(0, 1, 0, 4'b1111, 1, 4'b0001);
        add(0, 1, 0, 4'b1111, 1, 4'b0010);
        // Round-robin sparse after reset: 1,3,1,3.
        add(1, 1, 0, 4'b1010, 1, 4'b0010);
        add(0, 1, 0, 4'b1010, 1, 4'b1000);
        add(0, 1, 0, 4'b1010, 1, 4'b0010);
        add(0, 1, 0, 4'b1010, 1, 4'b1000);
        // Backpressure holds the ch3 beat, then the stream resumes at ch0.
        add(0, 1, 0, 4'b1111, 0, 4'b0000);
        add(0, 1, 0, 4'b1111, 0, 4'b0000);
        add(0, 1, 0, 4'b1111, 0, 4'b0000);
        add(0, 1, 0, 4'b1111, 1, 4'b0001);
        add(0, 1, 0, 4'b1111, 1, 4'b0010);
        add(0, 1, 0, 4'b1111, 1, 4'b0100);
        // Fixed sel=3 with ch3 idle: no transfer and the slot drains.
        // Switching to RR then serves ch3, the one after last-served ch2.
        add(0, 0, 3, 4'b0111, 1, 4'b0000);
        add(0, 0, 3, 4'b0111, 1, 4'b0000);
        add(0, 1, 3, 4'b1111, 1, 4'b1000);
        // Reset while the ch3 beat is held: beat dropped, RR restarts at ch0.
        add(1, 1, 0, 4'b1111, 1, 4'b0001);
        add(0, 1, 0, 4'b1111, 1, 4'b0010);
        // Fixed sel=1 under a stall, then a change of sel.
        add(0, 0, 1, 4'b1111, 0, 4'b0000);
        add(0, 0, 1, 4'b1111, 1, 4'b0010);
        add(0, 0, 0, 4'b1111, 1, 4'b0001);
        // Drain with no inputs.
        add(0, 1, 0, 4'b0000, 1, 4'b0000);
        add(0, 1, 0, 4'b0000, 1, 4'b0000);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_ch",    32'(out_ch),    32'd0);
        check("init_out_data",  32'(out_data),  32'd0);

        foreach (tbl[i]) run_row(i, tbl[i]);

        // A mode change must not disturb a beat already in the slot.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        drive_data(6'h3C);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        drive_data(6'h11);
        #1;
        check("hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_ch",    32'(out_ch),    32'd2);
        check("hold_out_data",  32'(out_data),  32'({6'h3C, 2'd2}));
        // Releasing the stall lets RR continue after ch2, i.e. at ch3.
        out_ready = 1'b1;
        #1;
        check("resume_in_ready", 32'(in_ready), 32'b1000);
        @(posedge clk);
        #1;
        check("resume_out_ch",   32'(out_ch),   32'd3);
        check("resume_out_data", 32'(out_data), 32'({6'h11, 2'd3}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
